rand_range: RTL
===============

Name: rand_range

Overview:
Downstream consumer of the lcg pseudo-random source. It converts the free-running 32-bit lcg output into an unbiased integer in [0, bound) on request. Game logic uses it for dice rolls, spawn positions and similar draws. It uses mask-and-reject sampling on the high-quality upper lcg bits, and falls back to an iterative modulo after too many rejections.

Parameters:
WIDTH, 16, width of bound and result
RAND_W, 32, width of lcg output (upper WIDTH bits are used)
MAX_TRIES, 8, rejections allowed before modulo fallback (>=1)

Ports:
clk  input  1  system clock; one clock domain
rst  input  1  synchronous, active-high reset
i_rand  input  RAND_W  lcg output; new value every cycle
i_req  input  1  draw request; sampled only in IDLE
i_bound  input  WIDTH  exclusive upper bound; sampled with i_req
o_value  output  WIDTH  result; held until the next result
o_valid  output  1  one-cycle pulse; o_value is new
o_err  output  1  set with o_valid when bound was 0; cleared on the next accepted request
o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE; o_value=0, o_valid=0, o_err=0, o_busy=0; try counter=0.
  - Takes priority over everything, including mid-MOD; any in-flight draw is discarded with no o_valid.
- Sample definition: s = i_rand[RAND_W-1 -: WIDTH].
- Mask: smallest 2^k-1 >= bound-1 (bound=1 gives mask 0; bound=6 gives 7; bound=65535 gives 0xFFFF).
  - Computed combinationally from i_bound and registered at request acceptance.
- States: IDLE, SAMPLE, MOD.
- IDLE:
  - On an edge E0 with i_req=1, latch bound and mask, set tries=0, clear o_err.
  - If bound==0: o_value<=0, o_err<=1, o_valid<=1, stay IDLE (pulse from E0).
  - Otherwise go to SAMPLE, o_busy<=1.
- SAMPLE, evaluated each edge:
  - If (s & mask) < bound: o_value<=(s & mask), o_valid<=1, go to IDLE.
  - Else tries++.
  - On reaching MAX_TRIES rejections: latch dividend=s (unmasked) and go to MOD.
- MOD: restoring division, one quotient bit per cycle, WIDTH cycles.
  - Remainder is kept WIDTH+1 bits wide to avoid overflow at bound near 2^WIDTH.
  - On the final iteration: o_value<=remainder, o_valid<=1, go to IDLE.
- Latency (edge at which o_valid rises):
  - Accept after k rejections: E0+1+k.
  - Fallback: E0+MAX_TRIES+WIDTH, which is 24 at defaults.
  - bound==0: E0.
- o_valid is high exactly one cycle per result.
- Simultaneous events:
  - A new i_req at the edge where o_valid falls (back in IDLE) is accepted.
  - i_req while busy is ignored with no queueing; i_bound changes while busy are ignored.
- Results are always < bound for bound>=1; bound=1 always yields 0 at E0+1.

Decomposition:
- Shared package: state enum (IDLE, SAMPLE, MOD), and the function computing the mask from bound.
- One natural sub-module: seq_mod, a WIDTH-cycle restoring remainder unit with start/done. It is reusable elsewhere in the game logic.

Test Plan:
- bound=6, i_rand=0x0003_1234 at E0 and E0+1 -> o_valid at E0+1, o_value=3, o_err=0, o_busy high for 1 cycle.
- bound=6, upper i_rand 0x0007, 0x0006, 0x0005 on E0+1..E0+3 -> two rejections, o_value=5 at E0+3.
- bound=6, upper i_rand stuck 0xFFFF -> 8 rejections then MOD, o_value=3 (65535 mod 6) at E0+24; a second i_req during MOD is ignored.
- bound=0 -> o_valid and o_err at E0, o_value=0; next request with bound=1 -> o_err cleared, o_value=0 at E0+1.
- rst=1 at an edge mid-MOD -> next cycle o_valid=0, o_busy=0, o_value=0; no late o_valid; a fresh request then completes normally.
- Back-to-back: i_req held high with bound=10 and lcg-driven i_rand for 1000 draws -> every o_value <9... every o_value <10, exactly one o_valid per accepted request, and a rough histogram shows all 10 values.

Source files
------------

// File: rtl/rand_range_pkg.sv
// rand_range_pkg: shared FSM state type and bound-to-mask helper for rand_range
package rand_range_pkg;

   typedef enum logic [1:0] {IDLE, SAMPLE, MOD} state_t;

   // Smallest all-ones value covering bound-1; fill every bit below the highest set bit
   function automatic logic [31:0] mask_of(input logic [31:0] bound);
      logic [31:0] m;
      m = bound - 32'd1;
      m = m | (m >> 1);
      m = m | (m >> 2);
      m = m | (m >> 4);
      m = m | (m >> 8);
      m = m | (m >> 16);
      return m;
   endfunction

endpackage

// File: rtl/rand_range_seq_mod.sv
// rand_range_seq_mod: WIDTH-cycle restoring remainder unit with start/done
module rand_range_seq_mod #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH);

   logic             active;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dq;
   logic [WIDTH-1:0] dv;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   nxt;

   // One restoring step; the extra top bit keeps the shifted remainder from overflowing near 2^WIDTH
   always_comb begin
      trial = {rem, dq[WIDTH-1]};
      nxt   = (trial >= {1'b0, dv}) ? trial - {1'b0, dv} : trial;
   end

   // done flags the final iteration so the caller can capture remainder on the same edge
   assign done      = active && (cnt == CW'(WIDTH - 1));
   assign remainder = nxt[WIDTH-1:0];

   // Load operands on start, then shift one dividend bit into the remainder per cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         cnt    <= '0;
         rem    <= '0;
         dq     <= '0;
         dv     <= '0;
      end else if (start) begin
         active <= 1'b1;
         cnt    <= '0;
         rem    <= '0;
         dq     <= dividend;
         dv     <= divisor;
      end else if (active) begin
         rem    <= nxt[WIDTH-1:0];
         dq     <= dq << 1;
         cnt    <= cnt + 1'b1;
         active <= !done;
      end
   end

endmodule

// File: rtl/rand_range.sv
// rand_range: unbiased draw in [0, bound) from lcg upper bits, mask-and-reject with modulo fallback
module rand_range
   import rand_range_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int RAND_W    = 32,
   parameter int MAX_TRIES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [RAND_W-1:0] i_rand,
   input  logic              i_req,
   input  logic [WIDTH-1:0]  i_bound,
   output logic [WIDTH-1:0]  o_value,
   output logic              o_valid,
   output logic              o_err,
   output logic              o_busy
);

   localparam int TW = $clog2(MAX_TRIES + 1);

   state_t           state;
   logic [WIDTH-1:0] bound_r;
   logic [WIDTH-1:0] mask_r;
   logic [TW-1:0]    tries;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] sm;
   logic [WIDTH-1:0] mask;
   logic             hit;
   logic             start;
   logic             done;
   logic [WIDTH-1:0] rem;
   logic             unused_low;

   // Upper lcg bits are the well-mixed ones; the low bits are deliberately ignored
   assign s          = i_rand[RAND_W-1 -: WIDTH];
   assign unused_low = ^i_rand[RAND_W-WIDTH-1:0];
   assign mask       = WIDTH'(mask_of(32'(i_bound)));
   assign sm         = s & mask_r;
   assign hit        = sm < bound_r;
   assign start      = (state == SAMPLE) && !hit && (tries == TW'(MAX_TRIES - 1));
   assign o_busy     = state != IDLE;

   rand_range_seq_mod #(.WIDTH(WIDTH)) u_mod (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .dividend (s),
      .divisor  (bound_r),
      .done     (done),
      .remainder(rem)
   );

   // Draw FSM: accept in IDLE, retry masked samples, fall back to modulo after MAX_TRIES rejections
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         o_value <= '0;
         o_valid <= 1'b0;
         o_err   <= 1'b0;
         tries   <= '0;
         bound_r <= '0;
         mask_r  <= '0;
      end else begin
         o_valid <= 1'b0;
         case (state)
            IDLE: if (i_req) begin
               bound_r <= i_bound;
               mask_r  <= mask;
               tries   <= '0;
               o_err   <= i_bound == '0;
               if (i_bound == '0) begin
                  o_value <= '0;
                  o_valid <= 1'b1;
               end else begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: if (hit) begin
               o_value <= sm;
               o_valid <= 1'b1;
               state   <= IDLE;
            end else if (start) begin
               state <= MOD;
            end else begin
               tries <= tries + 1'b1;
            end
            MOD: if (done) begin
               o_value <= rem;
               o_valid <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
